// File: rtl/sequential_alu_pkg.sv
// rtl/sequential_alu_pkg.sv - shared op encoding, FSM states and strobe decode for the sequential ALU family
package sequential_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic add;
    logic sub;
    logic mul;
    logic div;
  } strobe_t;

  // One-hot strobe for an op code; exactly one field is set for every legal op.
  function automatic strobe_t decode_strobe(input logic [1:0] op);
    strobe_t s;
    s = '0;
    unique case (op)
      OP_ADD:  s.add = 1'b1;
      OP_SUB:  s.sub = 1'b1;
      OP_MUL:  s.mul = 1'b1;
      default: s.div = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_watchdog.sv
// rtl/alu_watchdog.sv - cycle counter that flags an ALU that never accepts
module alu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is combinational so the driver can leave ISSUE in the same cycle.
  assign o_expire = i_enable && (cnt_q == LAST);

  // Next count: clear wins, otherwise count enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sequential_alu_driver.sv
// rtl/sequential_alu_driver.sv - command sequencer driving a sequential_alu and returning its results
module sequential_alu_driver
  import sequential_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_add,
  output logic                  o_sub,
  output logic                  o_mul,
  output logic                  o_div,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_ovf,
  input  logic                  i_accept,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_res_q,
  output logic                  o_res_ovf,
  output logic                  o_res_err,
  output logic [1:0]            o_res_op
);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q_q, res_q_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  res_err_q, res_err_d;

  logic    div_by_zero;
  logic    wd_enable;
  logic    wd_clear;
  logic    wd_expire;
  strobe_t strobe;

  // A divide by zero is answered locally without ever touching the ALU.
  assign div_by_zero = (i_cmd_op == OP_DIV) && (i_cmd_b == '0);

  // The watchdog only runs while waiting on the ALU; any other state rearms it.
  assign wd_enable = (state_q == ST_ISSUE) && !i_accept;
  assign wd_clear  = (state_q != ST_ISSUE);

  alu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (wd_clear),
    .i_enable (wd_enable),
    .o_expire (wd_expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; accept and timeout both end ISSUE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_d = div_by_zero ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_accept || wd_expire) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state and op, never on the command inputs.
  always_comb begin
    o_cmd_ready = (state_q == ST_IDLE);
    o_res_valid = (state_q == ST_RESP);
    strobe      = '0;
    if (state_q == ST_ISSUE) begin
      strobe = decode_strobe(op_q);
    end
  end

  assign o_add     = strobe.add;
  assign o_sub     = strobe.sub;
  assign o_mul     = strobe.mul;
  assign o_div     = strobe.div;
  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_res_q   = res_q_q;
  assign o_res_ovf = res_ovf_q;
  assign o_res_err = res_err_q;
  assign o_res_op  = op_q;

  // Datapath next-state: operands latch on the command, results on accept or timeout.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_q_d   = res_q_q;
    res_ovf_d = res_ovf_q;
    res_err_d = res_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          op_d = i_cmd_op;
          a_d  = i_cmd_a;
          b_d  = i_cmd_b;
          if (div_by_zero) begin
            res_q_d   = '0;
            res_ovf_d = 1'b1;
            res_err_d = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        if (i_accept) begin
          res_q_d   = i_q;
          res_ovf_d = i_ovf;
          res_err_d = 1'b0;
        end else if (wd_expire) begin
          res_q_d   = '0;
          res_ovf_d = 1'b0;
          res_err_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q_q   <= '0;
      res_ovf_q <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q_q   <= res_q_d;
      res_ovf_q <= res_ovf_d;
      res_err_q <= res_err_d;
    end
  end

endmodule

// File: tb/tb_sequential_alu_driver.sv
// tb/tb_sequential_alu_driver.sv - scoreboard bench for sequential_alu_driver with a behavioural ALU
module tb_sequential_alu_driver;

  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] q;
    logic        ovf;
    logic        err;
    int          lat;
    int          strobes;
    longint      hs_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_op = '0;
  logic [DW-1:0] i_cmd_a = '0;
  logic [DW-1:0] i_cmd_b = '0;
  logic [DW-1:0] o_a, o_b;
  logic          o_add, o_sub, o_mul, o_div;
  logic [DW-1:0] i_q = '0;
  logic          i_ovf = 1'b0;
  logic          i_accept = 1'b0;
  logic          o_res_valid;
  logic          i_res_ready = 1'b1;
  logic [DW-1:0] o_res_q;
  logic          o_res_ovf, o_res_err;
  logic [1:0]    o_res_op;

  sequential_alu_driver #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_a(o_a), .o_b(o_b), .o_add(o_add), .o_sub(o_sub), .o_mul(o_mul), .o_div(o_div),
    .i_q(i_q), .i_ovf(i_ovf), .i_accept(i_accept),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_q(o_res_q), .o_res_ovf(o_res_ovf), .o_res_err(o_res_err), .o_res_op(o_res_op)
  );

  always #5 i_clk = ~i_clk;

  longint cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Current outstanding command as seen by the ALU model.
  logic [1:0]  cur_op = '0;
  logic [31:0] cur_a = '0, cur_b = '0;
  int          cur_delay = 0;
  int          strobe_cycles = 0;
  bit          ready_auto = 1'b1;
  bit          ready_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed ALU semantics: exact result, truncated to 32 bits, overflow when it does not fit.
  function automatic void ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic ovf);
    longint sa, sbv, r;
    sa  = $signed(a);
    sbv = $signed(b);
    case (op)
      2'd0:    r = sa + sbv;
      2'd1:    r = sa - sbv;
      2'd2:    r = sa * sbv;
      default: r = (sbv == 0) ? 0 : sa / sbv;
    endcase
    q   = r[31:0];
    ovf = (r != longint'($signed(r[31:0])));
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] op);
    logic [3:0] v;
    v = 4'b1000;
    return v >> op;
  endfunction

  // Behavioural ALU: accepts in the cur_delay-th strobe cycle (0 = never), random noise otherwise.
  always @(negedge i_clk) begin
    logic [3:0]  stb;
    logic [31:0] rq;
    logic        rovf;
    int          issue_n;
    stb = {o_add, o_sub, o_mul, o_div};
    if (stb != 4'b0000) begin
      strobe_cycles++;
      issue_n++;
      chk("strobe_onehot", 64'(stb), 64'(onehot(cur_op)));
      chk("operand_a", 64'(o_a), 64'(cur_a));
      chk("operand_b", 64'(o_b), 64'(cur_b));
      chk("cmd_ready_issue", 64'(o_cmd_ready), 64'd0);
      if (cur_delay != 0 && issue_n == cur_delay) begin
        ref_alu(cur_op, o_a, o_b, rq, rovf);
        i_accept = 1'b1;
        i_q      = rq;
        i_ovf    = rovf;
      end else begin
        i_accept = 1'b0;
        i_q      = $urandom;
        i_ovf    = 1'($urandom);
      end
    end else begin
      issue_n  = 0;
      i_accept = ($urandom_range(0, 2) == 0);
      i_q      = $urandom;
      i_ovf    = 1'($urandom);
    end
  end

  // Result monitor: latency, strobe count and hold-stability checks, then pop and compare.
  always @(negedge i_clk) begin
    exp_t        e;
    bit          presented;
    logic [31:0] hq;
    logic        hovf, herr;
    logic [1:0]  hop;
    if (i_rst) begin
      presented = 1'b0;
    end else if (o_res_valid) begin
      chk("cmd_ready_resp", 64'(o_cmd_ready), 64'd0);
      chk("strobes_resp", 64'({o_add, o_sub, o_mul, o_div}), 64'd0);
      if (!presented) begin
        hq = o_res_q; hovf = o_res_ovf; herr = o_res_err; hop = o_res_op;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=valid expected=none q=%0h (t=%0t)", o_res_q, $time);
        end else begin
          e = sb[0];
          chk("latency", 64'(cyc - e.hs_cyc), 64'(e.lat));
          chk("strobe_cycles", 64'(strobe_cycles), 64'(e.strobes));
        end
      end else begin
        chk("hold_q", 64'(o_res_q), 64'(hq));
        chk("hold_ovf", 64'(o_res_ovf), 64'(hovf));
        chk("hold_err", 64'(o_res_err), 64'(herr));
        chk("hold_op", 64'(o_res_op), 64'(hop));
      end
      if (i_res_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("res_q", 64'(o_res_q), 64'(e.q));
        chk("res_ovf", 64'(o_res_ovf), 64'(e.ovf));
        chk("res_err", 64'(o_res_err), 64'(e.err));
        chk("res_op", 64'(o_res_op), 64'(e.op));
      end
      presented = !i_res_ready;
    end else begin
      presented = 1'b0;
    end
  end

  // Result-ready driver.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (ready_auto) i_res_ready = ready_rand ? 1'($urandom) : 1'b1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int delay);
    exp_t e;
    int   n;
    bit   ok;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_op = op;
    i_cmd_a  = a;
    i_cmd_b  = b;
    n  = 0;
    ok = 1'b1;
    forever begin
      @(negedge i_clk);
      if (o_cmd_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL cmd_ready_wait actual=0 expected=1 (t=%0t)", $time);
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      e.op = op;
      e.hs_cyc = cyc;
      if (op == 2'd3 && b == 32'd0) begin
        e.q = '0; e.ovf = 1'b1; e.err = 1'b0; e.lat = 1; e.strobes = 0;
      end else if (delay == 0) begin
        e.q = '0; e.ovf = 1'b0; e.err = 1'b1; e.lat = TO + 1; e.strobes = TO;
      end else begin
        ref_alu(op, a, b, e.q, e.ovf);
        e.err = 1'b0; e.lat = delay + 1; e.strobes = delay;
      end
      sb.push_back(e);
      cur_op = op; cur_a = a; cur_b = b; cur_delay = delay;
      strobe_cycles = 0;
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_op = 2'($urandom);
    i_cmd_a  = $urandom;
    i_cmd_b  = $urandom;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending results", sb.size());
    end
  endtask

  initial begin
    int n;
    logic [1:0]  op;
    logic [31:0] a, b;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_strobes", 64'({o_add, o_sub, o_mul, o_div}), 64'd0);
    chk("rst_res_valid", 64'(o_res_valid), 64'd0);
    chk("rst_res_flags", 64'({o_res_ovf, o_res_err}), 64'd0);
    chk("rst_operands", {o_a, o_b}, 64'd0);
    chk("rst_res_q_op", 64'({o_res_q, o_res_op}), 64'd0);

    send(2'd0, 32'd1, 32'd1, 3);
    send(2'd1, 32'h8000_0000, 32'd1, 2);
    send(2'd3, 32'd5, 32'd0, 1);
    send(2'd2, 32'd7, 32'd7, 1);
    wait_idle();

    // Result held while the consumer stalls.
    ready_auto = 1'b0;
    i_res_ready = 1'b0;
    send(2'd2, 32'd7, 32'hFFFF_FFF9, 2);
    n = 0;
    while (!o_res_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("stall_q", 64'(o_res_q), 64'hFFFF_FFCF);
      chk("stall_valid", 64'(o_res_valid), 64'd1);
      chk("stall_cmd_ready", 64'(o_cmd_ready), 64'd0);
      @(negedge i_clk);
    end
    @(posedge i_clk);
    #1;
    i_res_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("after_stall_idle", 64'({o_cmd_ready, o_res_valid}), 64'b10);
    ready_auto = 1'b1;

    // ALU that never answers.
    send(2'd0, 32'd3, 32'd4, 0);
    wait_idle();

    // Reset in the second ISSUE cycle discards the op.
    send(2'd2, 32'd7, 32'd7, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_strobes", 64'({o_add, o_sub, o_mul, o_div}), 64'd0);
    chk("midrst_res_valid", 64'(o_res_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    void'(sb.pop_back());
    repeat (25) @(negedge i_clk);

    // Randomised traffic with a stalling consumer.
    ready_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      a  = rand_opnd();
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : rand_opnd();
      send(op, a, b, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5)));
    end
    wait_idle();
    repeat (5) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
